// File: rtl/rx_pack_buffer_if.sv
// Stream bundle for rx_pack_buffer: 16-bit MAC-side input beats and 64-bit AXI-Stream output words.
// The slave view belongs to the buffer and the master view to whatever drives it.
interface rx_pack_buffer_if;
    logic [15:0] s_data_i;
    logic [1:0]  s_keep_i;
    logic        s_valid_i;
    logic        s_last_i;
    logic        s_err_i;
    logic [63:0] m_data_o;
    logic [7:0]  m_keep_o;
    logic        m_last_o;
    logic        m_valid_o;
    logic        m_ready_i;

    modport slave (
        input  s_data_i, s_keep_i, s_valid_i, s_last_i, s_err_i, m_ready_i,
        output m_data_o, m_keep_o, m_last_o, m_valid_o
    );

    modport master (
        output s_data_i, s_keep_i, s_valid_i, s_last_i, s_err_i, m_ready_i,
        input  m_data_o, m_keep_o, m_last_o, m_valid_o
    );
endinterface

// File: rtl/rx_pack_buffer.sv
// Receive store-and-forward buffer: packs 16-bit MAC beats into 64-bit RAM entries and
// forwards only complete, error-free frames; bad or oversize frames are rewound in place.
module rx_pack_buffer #(
    parameter int DEPTH = 512
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    rx_pack_buffer_if.slave   bus,
    output logic [15:0]       frames_o,
    output logic [15:0]       drops_o
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int ENT_W  = 73;

    typedef logic [PTR_W-1:0] ptr_t;

    // ------------------------------------------------------------------
    // Packer
    // ------------------------------------------------------------------
    logic [1:0]  lane_reg;
    logic [15:0] shadow_reg [3];
    logic [15:0] lane_data  [4];
    logic [1:0]  lane_keep  [4];
    logic        ovf_reg;

    ptr_t wr_ptr_reg, cm_ptr_reg, rd_ptr_reg;
    ptr_t occupancy;
    logic full;
    logic emit, eof, ovf_now, do_write, commit, drop;

    logic [63:0]      entry_data;
    logic [7:0]       entry_keep;
    logic [ENT_W-1:0] entry_word;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            if (gi < 3) begin : g_shadowed
                assign lane_data[gi] = (lane_reg == 2'(gi)) ? bus.s_data_i :
                                       (lane_reg >  2'(gi)) ? shadow_reg[gi] : 16'h0000;
            end else begin : g_top
                assign lane_data[gi] = (lane_reg == 2'(gi)) ? bus.s_data_i : 16'h0000;
            end
            assign lane_keep[gi] = (lane_reg == 2'(gi)) ? (bus.s_last_i ? bus.s_keep_i : 2'b11) :
                                   (lane_reg >  2'(gi)) ? 2'b11 : 2'b00;
        end
    endgenerate

    assign entry_data = {lane_data[3], lane_data[2], lane_data[1], lane_data[0]};
    assign entry_keep = {lane_keep[3], lane_keep[2], lane_keep[1], lane_keep[0]};
    assign entry_word = {bus.s_last_i, entry_keep, entry_data};

    assign occupancy = wr_ptr_reg - rd_ptr_reg;
    assign full      = (occupancy == ptr_t'(DEPTH));
    assign emit      = bus.s_valid_i && ((lane_reg == 2'd3) || bus.s_last_i);
    assign eof       = bus.s_valid_i && bus.s_last_i;
    // A frame that hits a full buffer on its closing entry is already lost.
    assign ovf_now   = ovf_reg || (emit && full);
    assign do_write  = emit && !full && !ovf_reg;
    assign commit    = eof && !bus.s_err_i && !ovf_now;
    assign drop      = eof && !commit;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_shadow
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    shadow_reg[gi] <= 16'h0000;
                end else if (bus.s_valid_i) begin
                    shadow_reg[gi] <= emit ? 16'h0000 : lane_data[gi];
                end
            end
        end
    endgenerate

    logic [15:0] frames_reg, drops_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_reg   <= 2'd0;
            ovf_reg    <= 1'b0;
            wr_ptr_reg <= '0;
            cm_ptr_reg <= '0;
            frames_reg <= 16'h0000;
            drops_reg  <= 16'h0000;
        end else begin
            if (bus.s_valid_i) begin
                lane_reg <= emit ? 2'd0 : lane_reg + 2'd1;
            end
            if (eof) begin
                ovf_reg <= 1'b0;
            end else if (emit && full) begin
                ovf_reg <= 1'b1;
            end
            if (drop) begin
                wr_ptr_reg <= cm_ptr_reg;
            end else if (do_write) begin
                wr_ptr_reg <= wr_ptr_reg + ptr_t'(1);
            end
            // A commit always coincides with the write of the frame's final entry.
            if (commit) begin
                cm_ptr_reg <= wr_ptr_reg + ptr_t'(1);
            end
            if (commit && (frames_reg != 16'hFFFF)) begin
                frames_reg <= frames_reg + 16'd1;
            end
            if (drop && (drops_reg != 16'hFFFF)) begin
                drops_reg <= drops_reg + 16'd1;
            end
        end
    end

    assign frames_o = frames_reg;
    assign drops_o  = drops_reg;

    // ------------------------------------------------------------------
    // Entry RAM with registered read
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] mem [DEPTH];
    logic [ENT_W-1:0] ram_q;
    logic             rd_issue;

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= entry_word;
        end
        if (rd_issue) begin
            ram_q <= mem[rd_ptr_reg[ADDR_W-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Reader: output register plus one prefetch slot
    // ------------------------------------------------------------------
    logic             out_valid_reg, pf_valid_reg, rd_pend_reg;
    logic [ENT_W-1:0] out_reg, pf_reg;
    logic             pop, out_free;
    logic [1:0]       held, held_after;

    assign pop        = out_valid_reg && bus.m_ready_i;
    assign out_free   = !out_valid_reg || pop;
    // Words held or in flight; a new read is issued only if it will have a slot to land in.
    assign held       = 2'(out_valid_reg) + 2'(pf_valid_reg) + 2'(rd_pend_reg);
    assign held_after = held - 2'(pop);
    assign rd_issue   = (rd_ptr_reg != cm_ptr_reg) && (held_after < 2'd2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_reg    <= '0;
            rd_pend_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            pf_valid_reg  <= 1'b0;
            out_reg       <= '0;
            pf_reg        <= '0;
        end else begin
            if (rd_issue) begin
                rd_ptr_reg <= rd_ptr_reg + ptr_t'(1);
            end
            rd_pend_reg <= rd_issue;
            if (out_free) begin
                if (pf_valid_reg) begin
                    out_reg       <= pf_reg;
                    out_valid_reg <= 1'b1;
                    pf_valid_reg  <= rd_pend_reg;
                    if (rd_pend_reg) begin
                        pf_reg <= ram_q;
                    end
                end else if (rd_pend_reg) begin
                    out_reg       <= ram_q;
                    out_valid_reg <= 1'b1;
                end else begin
                    out_valid_reg <= 1'b0;
                end
            end else if (rd_pend_reg) begin
                pf_reg       <= ram_q;
                pf_valid_reg <= 1'b1;
            end
        end
    end

    assign bus.m_data_o  = out_reg[63:0];
    assign bus.m_keep_o  = out_reg[71:64];
    assign bus.m_last_o  = out_reg[72];
    assign bus.m_valid_o = out_valid_reg;
endmodule
